thread_issue_scheduler: RTL and testbench

//  Fine-grained multithreaded issue scheduler in front of the per-thread register file bank.

---
 rtl/thread_issue_scheduler_pkg.sv | 24 ++
 rtl/thread_issue_scheduler_rr_arbiter.sv | 29 ++
 rtl/thread_issue_scheduler.sv | 107 ++++++++++
 tb/tb_thread_issue_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/thread_issue_scheduler_pkg.sv
// rtl/thread_issue_scheduler_pkg.sv - shared sizes, types and helpers for the thread issue scheduler
package sched_pkg;

    localparam int DEF_NUM_TH_LOG2 = 2;
    localparam int DEF_ADDR_WIDTH  = 4;
    localparam int NT              = 1 << DEF_NUM_TH_LOG2;
    localparam int NR              = 1 << DEF_ADDR_WIDTH;

    typedef logic [DEF_NUM_TH_LOG2-1:0] th_id_t;
    typedef logic [DEF_ADDR_WIDTH-1:0]  reg_addr_t;

    // Wide input so any thread count up to 64 can share one encoder.
    function automatic int unsigned onehot_to_id(input logic [63:0] oh);
        int unsigned id;
        id = 0;
        for (int i = 0; i < 64; i++) begin
            if (oh[i]) begin
                id = id | i;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/thread_issue_scheduler_rr_arbiter.sv
// rtl/thread_issue_scheduler_rr_arbiter.sv - combinational round-robin arbiter, priority starts after last_grant
module rr_arbiter #(
    parameter int N  = 4,
    parameter int TW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic [TW-1:0]  shift;
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] dbl_gnt;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;

    // N is a power of two, so the TW-bit add wraps modulo N.
    always_comb begin
        shift   = last_grant + 1'b1;
        dbl_req = {req, req} >> shift;
        rot_req = dbl_req[N-1:0];
        rot_gnt = rot_req & (-rot_req);
        dbl_gnt = {rot_gnt, rot_gnt} << shift;
        grant   = dbl_gnt[2*N-1:N];
        any     = |req;
    end

endmodule

// File: rtl/thread_issue_scheduler.sv
// rtl/thread_issue_scheduler.sv - round-robin thread issue with per-thread register scoreboard
// Optional SCHED_WB_BYPASS_EN: same-cycle writeback releases the hazard it retires.
module thread_issue_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_TH_LOG2 = DEF_NUM_TH_LOG2,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [(1<<NUM_TH_LOG2)-1:0]            thread_en,
    input  logic [(1<<NUM_TH_LOG2)-1:0]            inst_valid,
    input  logic [(1<<NUM_TH_LOG2)*ADDR_WIDTH-1:0] inst_src0,
    input  logic [(1<<NUM_TH_LOG2)*ADDR_WIDTH-1:0] inst_src1,
    input  logic [(1<<NUM_TH_LOG2)*ADDR_WIDTH-1:0] inst_dst,
    input  logic [(1<<NUM_TH_LOG2)-1:0]            inst_wr,
    input  logic                                   stall_in,
    input  logic                                   wb_en,
    input  logic [NUM_TH_LOG2-1:0]                 wb_th_id,
    input  logic [ADDR_WIDTH-1:0]                  wb_addr,
    output logic                                   issue_valid,
    output logic [NUM_TH_LOG2-1:0]                 issue_th_id,
    output logic [(1<<NUM_TH_LOG2)-1:0]            issue_grant
);

    localparam int TH_N  = 1 << NUM_TH_LOG2;
    localparam int REG_N = 1 << ADDR_WIDTH;
    localparam int TW    = NUM_TH_LOG2;
    localparam int AW    = ADDR_WIDTH;

    logic [TH_N-1:0][REG_N-1:0] sb_q, sb_d;
    logic [TW-1:0]              last_grant_q, last_grant_d;

    logic [TH_N-1:0][REG_N-1:0] pend_view;
    logic [TH_N-1:0]            ready;
    logic [TH_N-1:0]            req;
    logic [TH_N-1:0]            grant;
    logic                       any;
    logic [AW-1:0]              s0, s1, dst, iss_dst;

    // Register 0 is never a hazard, whatever the stored bit says.
    always_comb begin
        pend_view = sb_q;
`ifdef SCHED_WB_BYPASS_EN
        if (wb_en) begin
            pend_view[wb_th_id][wb_addr] = 1'b0;
        end
`endif
        for (int t = 0; t < TH_N; t++) begin
            pend_view[t][0] = 1'b0;
        end

        ready = '0;
        s0    = '0;
        s1    = '0;
        dst   = '0;
        for (int t = 0; t < TH_N; t++) begin
            s0  = inst_src0[t*AW +: AW];
            s1  = inst_src1[t*AW +: AW];
            dst = inst_dst[t*AW +: AW];
            ready[t] = thread_en[t] & inst_valid[t]
                     & ~(pend_view[t][s0] | pend_view[t][s1] | (inst_wr[t] & pend_view[t][dst]));
        end
        req = ready & {TH_N{~stall_in & rst_n}};
    end

    rr_arbiter #(
        .N  (TH_N),
        .TW (TW)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any        (any)
    );

    assign issue_valid = any;
    assign issue_grant = grant;
    assign issue_th_id = TW'(onehot_to_id(64'(grant)));
    assign iss_dst     = inst_dst[issue_th_id*AW +: AW];

    // Clear first, then set, so a new writer keeps ownership on a same-edge collision.
    always_comb begin
        sb_d         = sb_q;
        last_grant_d = last_grant_q;
        if (wb_en && (wb_addr != '0)) begin
            sb_d[wb_th_id][wb_addr] = 1'b0;
        end
        if (any) begin
            last_grant_d = issue_th_id;
            if (inst_wr[issue_th_id] && (iss_dst != '0)) begin
                sb_d[issue_th_id][iss_dst] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q         <= '0;
            last_grant_q <= '1;
        end else begin
            sb_q         <= sb_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_thread_issue_scheduler.sv
// tb/tb_thread_issue_scheduler.sv - directed scoreboard bench for thread_issue_scheduler
module tb_thread_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  thread_en, inst_valid, inst_wr;
    logic [15:0] inst_src0, inst_src1, inst_dst;
    logic        stall_in, wb_en;
    logic [1:0]  wb_th_id;
    logic [3:0]  wb_addr;
    logic        issue_valid;
    logic [1:0]  issue_th_id;
    logic [3:0]  issue_grant;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];
    bit m_sb[4][16];
    int m_last;

    always #5 clk = ~clk;

    thread_issue_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .thread_en   (thread_en),
        .inst_valid  (inst_valid),
        .inst_src0   (inst_src0),
        .inst_src1   (inst_src1),
        .inst_dst    (inst_dst),
        .inst_wr     (inst_wr),
        .stall_in    (stall_in),
        .wb_en       (wb_en),
        .wb_th_id    (wb_th_id),
        .wb_addr     (wb_addr),
        .issue_valid (issue_valid),
        .issue_th_id (issue_th_id),
        .issue_grant (issue_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inst(input int t, input logic [3:0] s0, input logic [3:0] s1,
                            input logic [3:0] d, input logic wr);
        inst_src0[t*4 +: 4] = s0;
        inst_src1[t*4 +: 4] = s1;
        inst_dst[t*4 +: 4]  = d;
        inst_wr[t]          = wr;
    endtask

    function automatic bit m_pend(input int t, input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
`ifdef SCHED_WB_BYPASS_EN
        if (wb_en && (int'(wb_th_id) == t) && (wb_addr == r)) return 1'b0;
`endif
        return m_sb[t][r];
    endfunction

    task automatic model(output bit v, output int id);
        v  = 1'b0;
        id = 0;
        if (!stall_in) begin
            for (int k = 1; k <= 4; k++) begin
                int t;
                t = (m_last + k) % 4;
                if (!v && thread_en[t] && inst_valid[t]
                    && !m_pend(t, inst_src0[t*4 +: 4]) && !m_pend(t, inst_src1[t*4 +: 4])
                    && !(inst_wr[t] && m_pend(t, inst_dst[t*4 +: 4]))) begin
                    v  = 1'b1;
                    id = t;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 16; r++)
                m_sb[t][r] = 1'b0;
        m_last = 3;
    endtask

    // One cycle: model prediction queued, DUT compared at negedge, model advanced at posedge.
    task automatic step(input bit dchk, input bit dv, input int did);
        bit v;
        int id;
        logic [2:0] e;
        logic [3:0] d;
        model(v, id);
        exp_q.push_back({v, 2'(id)});
        @(negedge clk);
        e = exp_q.pop_front();
        chk("valid", 32'(issue_valid), 32'(e[2]));
        chk("th_id", 32'(issue_th_id), e[2] ? 32'(e[1:0]) : 32'd0);
        chk("grant", 32'(issue_grant), e[2] ? (32'd1 << e[1:0]) : 32'd0);
        if (dchk) begin
            chk("dir_valid", 32'(issue_valid), 32'(dv));
            if (dv) chk("dir_th", 32'(issue_th_id), 32'(did));
        end
        @(posedge clk);
        if (wb_en && wb_addr != 4'd0) m_sb[wb_th_id][wb_addr] = 1'b0;
        if (v) begin
            d = inst_dst[id*4 +: 4];
            if (inst_wr[id] && d != 4'd0) m_sb[id][d] = 1'b1;
            m_last = id;
        end
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        thread_en  = 4'hF;
        inst_valid = 4'hF;
        inst_wr    = 4'h0;
        inst_src0  = '0;
        inst_src1  = '0;
        inst_dst   = '0;
        stall_in   = 1'b0;
        wb_en      = 1'b0;
        wb_th_id   = 2'd0;
        wb_addr    = 4'd0;
        for (int i = 0; i < 4; i++) set_inst(i, 4'd1, 4'd2, 4'd0, 1'b0);
        model_reset();

        @(negedge clk);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_grant", 32'(issue_grant), 32'd0);
        chk("rst_th_id", 32'(issue_th_id), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // round robin from thread 0
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, k % 4);

        // RAW on th0 r5
        set_inst(0, 4'd1, 4'd2, 4'd5, 1'b1);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1, k % 4);
        set_inst(0, 4'd5, 4'd1, 4'd0, 1'b0);
        for (int k = 1; k <= 3; k++) step(1'b1, 1'b1, k);
        inst_valid = 4'b0001;
        step(1'b1, 1'b0, 0);
        wb_en = 1'b1; wb_th_id = 2'd0; wb_addr = 4'd5;
`ifdef SCHED_WB_BYPASS_EN
        step(1'b1, 1'b1, 0);
`else
        step(1'b1, 1'b0, 0);
`endif
        wb_en = 1'b0;
        step(1'b1, 1'b1, 0);

        // r0 never pending
        set_inst(0, 4'd1, 4'd2, 4'd0, 1'b1);
        step(1'b1, 1'b1, 0);
        set_inst(0, 4'd0, 4'd0, 4'd0, 1'b1);
        step(1'b1, 1'b1, 0);

        // stall with writeback to th2 r7
        inst_valid = 4'hF;
        set_inst(0, 4'd1, 4'd2, 4'd0, 1'b0);
        set_inst(2, 4'd1, 4'd2, 4'd7, 1'b1);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        set_inst(2, 4'd7, 4'd3, 4'd0, 1'b0);
        stall_in = 1'b1;
        wb_en = 1'b1; wb_th_id = 2'd2; wb_addr = 4'd7;
        step(1'b1, 1'b0, 0);
        wb_th_id = 2'd1; wb_addr = 4'd4;
        step(1'b1, 1'b0, 0);
        wb_en = 1'b0;
        step(1'b1, 1'b0, 0);
        stall_in = 1'b0;
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);

        // partial enable mask
        thread_en = 4'b1010;
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 1);

        // WAW pending in th1/th3, then reset mid-cycle
        thread_en = 4'hF;
        set_inst(1, 4'd1, 4'd2, 4'd9, 1'b1);
        set_inst(2, 4'd1, 4'd2, 4'd0, 1'b0);
        set_inst(3, 4'd1, 4'd2, 4'd10, 1'b1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 3);
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 2);
        step(1'b1, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(issue_valid), 32'd0);
        chk("mid_rst_grant", 32'(issue_grant), 32'd0);
        chk("mid_rst_th_id", 32'(issue_th_id), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
